// File: rtl/priority_drain.sv
// priority_drain: accepts an 8-bit request vector and emits its set bits one per
// transfer, highest index first. Optional `flush` port enabled by PRIORITY_DRAIN_FLUSH_EN.
module priority_drain #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_onehot,
  output logic [2:0]   out_idx,
  output logic         out_last
`ifdef PRIORITY_DRAIN_FLUSH_EN
  ,
  input  logic         flush
`endif
);

  localparam int IW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [W-1:0]   pending_r;
  logic [W-1:0]   pending_nxt_s;
  logic [W-1:0]   top_s;
  logic [IW-1:0]  idx_s;
  logic           last_s;
  logic           flush_s;

  // Highest set bit as a one-hot mask; a later (higher) hit overrides a lower one.
  function automatic logic [W-1:0] top_bit(input logic [W-1:0] v);
    logic [W-1:0] res;
    res = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        res    = {W{1'b0}};
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] onehot_to_idx(input logic [W-1:0] oh);
    logic [IW-1:0] res;
    res = {IW{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (oh[i]) begin
        res = IW'(i);
      end
    end
    return res;
  endfunction

`ifdef PRIORITY_DRAIN_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Output decode from registered pending only; pending is zero whenever idle.
  always_comb begin
    top_s  = top_bit(pending_r);
    idx_s  = onehot_to_idx(top_s);
    last_s = (pending_r != {W{1'b0}}) && ((pending_r & ~top_s) == {W{1'b0}});
  end

  assign out_onehot = top_s;
  assign out_idx    = idx_s;
  assign out_last   = last_s;
  assign out_valid  = (state_r == DRAIN);
  assign in_ready   = (state_r == IDLE) && reset_n;

  // Next-state: accept in IDLE, retire one bit per handshake in DRAIN, flush wins.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    case (state_r)
      IDLE: begin
        if (in_valid && (in_req != {W{1'b0}})) begin
          state_nxt_s   = DRAIN;
          pending_nxt_s = in_req;
        end else begin
          state_nxt_s   = IDLE;
          pending_nxt_s = {W{1'b0}};
        end
      end
      DRAIN: begin
        if (flush_s) begin
          state_nxt_s   = IDLE;
          pending_nxt_s = {W{1'b0}};
        end else if (out_ready) begin
          if (last_s) begin
            state_nxt_s   = IDLE;
            pending_nxt_s = {W{1'b0}};
          end else begin
            state_nxt_s   = DRAIN;
            pending_nxt_s = pending_r & ~top_s;
          end
        end else begin
          state_nxt_s   = DRAIN;
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = {W{1'b0}};
      end
    endcase
  end

  // State and pending registers; reset discards any partially drained vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      pending_r <= {W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

endmodule

// File: doc/priority_drain.md
# priority_drain

Sequential companion to the combinational priority one-hot selector. It accepts an 8-bit request vector through a valid/ready handshake and drains it one set bit per output transfer, from highest bit to lowest. Each transfer presents the bit both as a one-hot mask and as a 3-bit binary index. It sits between a request-collection stage and a single-issue consumer that can service only one request at a time.

## Interface
- `W`, default 8, is the request vector width. It is fixed at 8 in this revision, and the index width is 3.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_req` holds a vector to accept.
- `in_ready`, output, 1: the block can accept a vector this cycle.
- `in_req`, input, 8: request vector. Bit 7 has the highest priority.
- `out_valid`, output, 1: `out_idx`, `out_onehot` and `out_last` are valid.
- `out_ready`, input, 1: the consumer takes the current entry this cycle.
- `out_onehot`, output, 8: the highest set bit of the pending vector.
- `out_idx`, output, 3: binary index of `out_onehot`, 7 down to 0.
- `out_last`, output, 1: this entry is the final set bit of the vector.

## Operation
- **State:** a 1-bit FSM with states IDLE and DRAIN, plus an 8-bit `pending` register.
- **Reset values:** state = IDLE, `pending` = 0, `out_valid` = 0, `out_onehot` = 0, `out_idx` = 0, `out_last` = 0. `in_ready` is 0 while `reset_n` is low.
- **`in_ready`:** equals (state == IDLE) && `reset_n`.
- **Accepting a vector in IDLE:** when `in_valid` && `in_ready`:
  - If `in_req` != 0: `pending` <= `in_req` and the state moves to DRAIN.
  - If `in_req` == 0: the vector is consumed, no output is produced, and the state stays IDLE.
- **`out_valid`:** equals (state == DRAIN).
- **Output decode:**
  - `out_onehot` is the highest set bit of `pending`, using the same priority order as the selector.
  - `out_idx` is the binary encoding of that bit.
  - `out_last` = (`pending` & ~`out_onehot`) == 0.
  - All three outputs are decoded combinationally from registered `pending`, so they do not depend combinationally on `in_*` or `out_ready`.
- **Output handshake in DRAIN:** when `out_valid` && `out_ready`, `pending` <= `pending` & ~`out_onehot`. If `out_last` is set, the state returns to IDLE and `pending` becomes 0.
- **Back-pressure:** while `out_valid` && !`out_ready`, `pending` and all outputs hold stable.
- **Handshake rules:** `out_valid` never drops without a handshake. Each set bit is emitted exactly once, in strictly descending index order.
- **Vector overlap:** there is none. A new vector is accepted only in IDLE, never in the cycle that retires the last entry.

## Timing
- **Accept to first output:** a vector accepted at edge N gives `out_valid` = 1 in cycle N+1 with the top bit.
- **Drain length:** a vector with k set bits needs k output handshakes. With `out_ready` held high, `out_valid` is high for exactly k consecutive cycles.
- **Return to IDLE:** the edge that retires the `out_last` entry clears `out_valid` and raises `in_ready` in the following cycle.
- **Throughput:** at most one vector per k+1 cycles, and one zero vector per cycle.
- **Reset mid-drain:** asserting `reset_n` low immediately forces IDLE and `pending` = 0, and `out_valid` drops asynchronously. The remaining bits are discarded. Release is synchronised by the reset tree outside this block.

## Configuration
- **Macro `PRIORITY_DRAIN_FLUSH_EN`:** when defined, adds the port `flush`, input, 1.
  - If `flush` is high at an edge while in DRAIN, `pending` <= 0 and the state moves to IDLE, regardless of `out_ready`. The current entry is not counted as transferred.
  - `flush` in IDLE has no effect.
  - `flush` takes priority over an output handshake in the same cycle.
- **Macro not defined:** the port is absent and every vector is always fully drained.

## Test plan
- **Reset:** hold `reset_n` = 0, then release it. Expect `in_ready` = 0 during reset and 1 after release, and `out_valid` = 0, `out_onehot` = 0x00, `out_idx` = 0.
- **Mixed vector, no back-pressure:** accept `in_req` = 0xA5 with `out_ready` = 1. Expect the sequence idx 7, 5, 2, 0 with onehot 0x80, 0x20, 0x04, 0x01 on 4 consecutive cycles, `out_last` only on idx 0, and `in_ready` high the cycle after.
- **Back-pressure:** accept 0x18 and hold `out_ready` = 0 for 3 cycles. Expect idx 4 / onehot 0x10 held stable with `out_last` = 0. Then set `out_ready` = 1 and expect idx 3 with `out_last` = 1.
- **Zero and all-ones vectors:**
  - Accept 0x00. Expect no `out_valid` and `in_ready` staying 1.
  - Accept 0xFF. Expect idx 7 down to 0 over 8 transfers, with `in_ready` = 0 throughout.
- **Reset mid-drain:** accept 0xC3, complete 1 transfer (idx 7), then pulse `reset_n` low. Expect `out_valid` to drop immediately and no further entries after release.
- **Flush (`PRIORITY_DRAIN_FLUSH_EN` defined):** accept 0x0F, complete 1 transfer (idx 3), then assert `flush` together with `out_ready`. Expect IDLE the next cycle and idx 2 never presented as transferred.
